// File: rtl/prog_loader.sv
// Boot loader: assembles a framed big-endian byte stream into 32-bit words and writes them to instruction RAM.
// Latency: one WRITE cycle per word (5 cycles/word peak); rx_ready drops during WRITE, so the source holds its byte.
module prog_loader #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] DEPTH = 16'(MEM_DEPTH);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [15:0] word_idx;
    logic [7:0]  csum;
    logic [31:0] shreg;
    logic        accept;
    logic [15:0] n_hdr;

    assign accept = rx_valid & rx_ready;
    // Full header as it will be latched on this edge, so the size checks need no extra cycle.
    assign n_hdr  = {word_count[15:8], rx_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            byte_cnt   <= 2'd0;
            word_idx   <= 16'd0;
            csum       <= 8'd0;
            shreg      <= 32'd0;
            word_count <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_HDR_HI;
                        byte_cnt <= 2'd0;
                        word_idx <= 16'd0;
                        csum     <= 8'd0;
                    end
                end
                S_HDR_HI: begin
                    if (accept) begin
                        word_count[15:8] <= rx_data;
                        state            <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (accept) begin
                        word_count[7:0] <= rx_data;
                        if (n_hdr > DEPTH)
                            state <= S_ERR;
                        else if (n_hdr == 16'd0)
                            state <= S_CHK;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shreg    <= {shreg[23:0], rx_data};
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 16'd1;
                    if (word_idx + 16'd1 == word_count)
                        state <= S_CHK;
                    else
                        state <= S_DATA;
                end
                S_CHK: begin
                    if (accept)
                        state <= (rx_data == csum) ? S_DONE : S_ERR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rx_ready  = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                       (state == S_DATA)   || (state == S_CHK);
    assign busy      = rx_ready || (state == S_WRITE);
    assign mem_we    = (state == S_WRITE);
    assign mem_addr  = word_idx[ADDR_W-1:0];
    assign mem_wdata = shreg;
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);
    assign cpu_reset = (state != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as words are streamed and checked on mem_we.
module tb_prog_loader;
    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       word_count;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    logic [39:0] exp_q[$];
    logic [31:0] img[0:2];

    prog_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Write monitor: every mem_we pops one expected {addr,data}; handshake must be closed while writing.
    always @(negedge clk) begin
        if (mem_we) begin
            logic [39:0] e;
            wr_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    fails++;
                    $display("FAIL write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             mem_addr, mem_wdata, e[39:32], e[31:0]);
                end
            end
        end
        if (busy) begin
            tests++;
            if (rx_ready !== !mem_we) begin
                fails++;
                $display("FAIL ready_vs_write: rx_ready=%b mem_we=%b, required rx_ready=~mem_we", rx_ready, mem_we);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'hxx;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: rx_ready=%b, required 1 within 40 cycles", rx_ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams header N=n, img[0..n-1], then checksum XOR cs_flip; leaves the bench at a negedge.
    task automatic stream(input int n, input bit gap, input logic [7:0] cs_flip);
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'h00;
        pulse_start();
        send_byte(8'(n >> 8), gap);
        send_byte(8'(n), gap);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int k = 3; k >= 0; k--) begin
                if (k == 0) exp_q.push_back({8'(i), w});
                send_byte(w[8*k +: 8], gap);
                cs ^= w[8*k +: 8];
            end
        end
        send_byte(cs ^ cs_flip, gap);
    endtask

    task automatic check_end(input string name, input int n, input int writes, input bit ok);
        tests++;
        if (done !== ok || error !== !ok || cpu_reset !== !ok || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_status: done=%b error=%b cpu_reset=%b busy=%b, required done=%b error=%b cpu_reset=%b busy=0",
                     name, done, error, cpu_reset, busy, ok, !ok, !ok);
        end
        tests++;
        if (writes !== n || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_writes: got %0d writes (%0d pending), required %0d", name, writes, exp_q.size(), n);
        end
        tests++;
        if (word_count !== 16'(n)) begin
            fails++;
            $display("FAIL %s_word_count: got %0d, required %0d", name, word_count, n);
        end
    endtask

    task automatic check_reset_vals(input string name);
        tests++;
        if ({rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error, word_count} !==
            {1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL %s: rdy=%b we=%b addr=%0d wd=%08h cpu_rst=%b busy=%b done=%b err=%b wc=%0d, required 0 0 0 0 1 0 0 0 0",
                     name, rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error, word_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_values");
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("idle_after_reset");
    endtask

    task automatic test_nominal();
        int w0 = wr_cnt;
        stream(3, 1'b0, 8'h00);
        check_end("nominal", 3, wr_cnt - w0, 1'b1);
    endtask

    task automatic test_bad_checksum();
        int w0 = wr_cnt;
        stream(3, 1'b0, 8'h01);
        check_end("bad_checksum", 3, wr_cnt - w0, 1'b0);
    endtask

    task automatic test_empty();
        int w0 = wr_cnt;
        stream(0, 1'b0, 8'h00);
        check_end("empty_ok", 0, wr_cnt - w0, 1'b1);
        w0 = wr_cnt;
        stream(0, 1'b0, 8'hFF);
        check_end("empty_bad", 0, wr_cnt - w0, 1'b0);
    endtask

    task automatic test_oversize();
        int w0 = wr_cnt;
        pulse_start();
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0 || cpu_reset !== 1'b1) begin
            fails++;
            $display("FAIL restart_status: busy=%b done=%b error=%b cpu_reset=%b, required 1 0 0 1",
                     busy, done, error, cpu_reset);
        end
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (5) begin
            tests++;
            if (error !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
                fails++;
                $display("FAIL oversize_hold: error=%b rx_ready=%b busy=%b cpu_reset=%b, required 1 0 0 1",
                         error, rx_ready, busy, cpu_reset);
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        tests++;
        if (wr_cnt != w0 || word_count !== 16'd257) begin
            fails++;
            $display("FAIL oversize_result: writes=%0d word_count=%0d, required 0 and 257", wr_cnt - w0, word_count);
        end
    endtask

    task automatic test_gaps();
        int w0 = wr_cnt;
        stream(3, 1'b1, 8'h00);
        check_end("gaps", 3, wr_cnt - w0, 1'b1);
    endtask

    task automatic test_reset_midload();
        int w0;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        exp_q.push_back({8'd0, img[0]});
        for (int k = 3; k >= 0; k--) send_byte(img[0][8*k +: 8], 1'b0);
        send_byte(img[1][31:24], 1'b0);
        send_byte(img[1][23:16], 1'b0);
        rx_valid = 1'b1;
        rx_data  = img[1][15:8];
        #2 reset = 1'b0;
        #1 check_reset_vals("midload_async_reset");
        tests++;
        if (wr_cnt == 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL midload_first_word: pending=%0d, required first word written before reset", exp_q.size());
        end
        exp_q.delete();
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        w0 = wr_cnt;
        stream(3, 1'b0, 8'h00);
        check_end("restart", 3, wr_cnt - w0, 1'b1);
    endtask

    initial begin
        img[0] = 32'h20100005;
        img[1] = 32'h2011000A;
        img[2] = 32'h02119020;
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_empty();
        test_oversize();
        test_gaps();
        test_reset_midload();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the CPU's instruction RAM. It receives a framed byte stream (word count, big-endian instruction words, XOR checksum) and writes each assembled 32-bit word into instruction memory at consecutive word indices starting from 0. It holds the CPU in reset until a complete, checksum-valid image has been written. This replaces `$readmemh` preloading wherever a stream source is used, on the bench or on hardware.

## Interface
- MEM_DEPTH, 256, instruction RAM depth in 32-bit words.
- ADDR_W, $clog2(MEM_DEPTH), width of the word index.

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; low forces every register to its reset value immediately.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_valid  in  1  a byte is presented on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  the loader can accept a byte this cycle.
- mem_we  out  1  instruction-RAM write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word index being written.
- mem_wdata  out  32  assembled instruction word.
- cpu_reset  out  1  active-high reset to the CPU; high unless in DONE.
- busy  out  1  high in HDR_HI, HDR_LO, DATA, WRITE and CHK.
- done  out  1  high in DONE.
- error  out  1  high in ERR.
- word_count  out  16  word count N latched from the header.

## Operation
- Frame format, in order:
  - N as two bytes, high byte first.
  - N words of 4 bytes each, MSB first.
  - One checksum byte equal to the XOR of all 4N data bytes. The header is not included; for N=0 the checksum is 0x00.
- A byte is accepted on a rising edge where rx_valid and rx_ready are both 1. No other cycle consumes a byte.
- States:
  - IDLE: on start go to HDR_HI. Clear the byte counter, word index, checksum accumulator, error and done.
  - HDR_HI: accept a byte into N[15:8], then go to HDR_LO.
  - HDR_LO: accept a byte into N[7:0].
    - If N > MEM_DEPTH, go to ERR.
    - Else if N == 0, go to CHK.
    - Else go to DATA.
  - DATA: accept bytes into the shift register and XOR each into the accumulator. On the 4th byte (byte counter 3→0), go to WRITE.
  - WRITE: assert mem_we with the current mem_addr and mem_wdata. Then increment the word index. If the index reaches N, go to CHK; otherwise go back to DATA.
  - CHK: accept one byte. If it equals the accumulator, go to DONE; otherwise go to ERR.
  - DONE and ERR: hold until start, which goes to HDR_HI with the same clears as in IDLE.
- start while busy is ignored.
- rx_ready is 1 in HDR_HI, HDR_LO, DATA and CHK, and 0 in every other state.
- mem_wdata is valid only while mem_we is high. mem_addr equals the word index throughout, with its upper bits truncated to ADDR_W.
- Words already written before an ERR stay in RAM. No rollback is performed.
- Reset asserted mid-load returns the loader to IDLE. RAM contents are left as they are.

## Timing
- Reset values:
  - rx_ready 0, mem_we 0, mem_addr 0, mem_wdata 0
  - cpu_reset 1, busy 0, done 0, error 0, word_count 0
- All outputs are registered or decoded from registered state. There is no combinational path from rx_valid or rx_data to any output.
- mem_we is high for exactly the one cycle after the edge that accepted a word's 4th byte. rx_ready is 0 during that cycle, so the next byte is held by the source.
- Peak throughput is 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
- After the edge that accepts a matching checksum:
  - done=1, busy=0, cpu_reset=0 the following cycle.
- After the edge that accepts a mismatching checksum, or an oversize N:
  - error=1, cpu_reset stays 1.
- After start is sampled in DONE or ERR:
  - busy=1, done=0, error=0, cpu_reset=1 the following cycle.
- Gaps in rx_valid stall the loader without changing its state.

## Test plan
- Nominal load:
  - Stimulus: start, then stream 00 03 20 10 00 05 20 11 00 0A 02 11 90 20 followed by the correct XOR checksum.
  - Response: writes 0x20100005@0, 0x2011000A@1, 0x02119020@2. Each mem_we is one cycle. word_count=3, done=1, cpu_reset falls to 0.
- Bad checksum:
  - Stimulus: same stream with checksum XOR 0x01.
  - Response: all 3 writes occur, then error=1, done=0, cpu_reset remains 1.
- Empty image:
  - Stimulus: 00 00 00.
  - Response: no mem_we, done=1. Repeating with 00 00 FF gives error=1.
- Oversize:
  - Stimulus: 01 01 (N=257) with MEM_DEPTH=256.
  - Response: error=1 after HDR_LO, rx_ready=0, no mem_we, further bytes not consumed.
- Backpressure and gaps:
  - Stimulus: the nominal stream with rx_valid toggling every other cycle.
  - Response: identical writes and done. rx_ready=0 exactly in each WRITE cycle, and no byte is lost or duplicated.
- Reset mid-load and restart:
  - Stimulus: pull reset low after word 1 is written, while a byte is being presented.
  - Response: all outputs at reset values asynchronously. On release, start plus the nominal stream reproduces the nominal result.
